// File: rtl/ahb_params_pkg.sv
// AHB arbiter shared types: transfer/burst/response encodings,
// master ids, arbiter FSM states and a burst-length helper.
package ahb_params_pkg;

  localparam int NO_OF_MASTERS = 2;
  localparam int MW            = $clog2(NO_OF_MASTERS);
  localparam int BW            = 4;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'd0,
    HR_ERROR = 2'd1,
    HR_RETRY = 2'd2,
    HR_SPLIT = 2'd3
  } hresp_t;

  typedef enum logic [MW-1:0] {
    CPU = MW'(0),
    DMA = MW'(1)
  } hmaster_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BURST  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

  // Undefined-length bursts count as a single beat.
  function automatic int burst_beats(input hburst_t b);
    case (b)
      HB_WRAP4,  HB_INCR4:  return 4;
      HB_WRAP8,  HB_INCR8:  return 8;
      HB_WRAP16, HB_INCR16: return 16;
      default:              return 1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_beat_counter.sv
// Remaining-beat counter for a fixed-length AHB burst.
// Ports: i_clk, i_rst (sync, high), i_load/i_load_val (burst start),
//   i_dec (accepted SEQ), i_busy (hold), i_abort (clear), o_last.
module ahb_burst_beat_counter
  import ahb_params_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [BW-1:0] i_load_val,
  input  logic          i_dec,
  input  logic          i_busy,
  input  logic          i_abort,
  output logic          o_last
);

  logic [BW-1:0] r_beats_left;

  // Saturates at zero; abort beats load beats decrement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beats_left <= '0;
    end else if (i_abort) begin
      r_beats_left <= '0;
    end else if (i_load) begin
      r_beats_left <= i_load_val;
    end else if (i_dec && !i_busy &&
                 r_beats_left != '0) begin
      r_beats_left <= r_beats_left - 1'b1;
    end
  end

  // One beat (or none) left: the next accepted SEQ ends it.
  assign o_last = (r_beats_left <= BW'(1));

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Fixed-priority AHB arbiter with burst/lock protection and SPLIT masking.
// Ports: HCLK, HRESET (sync, high), HBUSREQ/HLOCK/HSPLIT per master,
//   HTRANS/HBURST/HREADY/HRESP bus status, HGRANT/HMASTER/HMASTLOCK out.
module ahb_bus_arbiter #(
  parameter int NO_OF_MASTERS = ahb_params_pkg::NO_OF_MASTERS,
  parameter logic [$clog2(NO_OF_MASTERS)-1:0] DEFAULT_MASTER =
    ahb_params_pkg::CPU
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
  input  logic [NO_OF_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                       HTRANS,
  input  logic [2:0]                       HBURST,
  input  logic                             HREADY,
  input  logic [1:0]                       HRESP,
  input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
  output logic [NO_OF_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
  output logic                             HMASTLOCK
);

  import ahb_params_pkg::*;

  localparam int NM = NO_OF_MASTERS;
  localparam int LW = $clog2(NM);
  localparam logic [NM-1:0] DEF_GNT =
    NM'(1) << DEFAULT_MASTER;

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [NM-1:0] r_hgrant;
  logic [NM-1:0] w_hgrant_nxt;
  logic [NM-1:0] r_split_mask;
  logic [NM-1:0] w_mask_nxt;
  logic [NM-1:0] w_split_set;
  logic [NM-1:0] w_req;
  logic [LW-1:0] r_hmaster;
  logic [LW-1:0] r_hmaster_d;
  logic [LW-1:0] w_gnt_idx;
  logic          r_hmastlock;

  htrans_t       w_trans;
  hburst_t       w_burst;
  hresp_t        w_resp;
  int            w_beats;
  logic          w_fixed;
  logic          w_own_lock;
  logic          w_gnt_any;
  logic          w_own_masked;
  logic          w_rearb_ok;
  logic          w_rearb;
  logic          w_busy;
  logic          w_cnt_load;
  logic          w_cnt_abort;
  logic          w_cnt_dec;
  logic          w_cnt_last;
  logic [BW-1:0] w_cnt_load_val;

  assign w_trans    = htrans_t'(HTRANS);
  assign w_burst    = hburst_t'(HBURST);
  assign w_resp     = hresp_t'(HRESP);
  assign w_beats    = burst_beats(w_burst);
  assign w_fixed    = (w_beats > 1);
  assign w_own_lock = HLOCK[r_hmaster];
  assign w_busy     = (w_trans == HT_BUSY);

  assign w_cnt_load_val = BW'(w_beats - 1);
  assign w_cnt_dec = (r_state == ARB_BURST) &&
                     (w_trans == HT_SEQ) && HREADY;

  // First cycle of a two-cycle SPLIT response.
  always_comb begin
    w_split_set = '0;
    if (w_resp == HR_SPLIT && !HREADY)
      w_split_set[r_hmaster_d] = 1'b1;
  end

  // Release first, then set, so a same-cycle set survives.
  assign w_mask_nxt = (r_split_mask & ~HSPLIT) | w_split_set;
  assign w_req      = HBUSREQ & ~w_mask_nxt;

  // Lowest index wins; park on default if it is unmasked.
  always_comb begin
    w_hgrant_nxt = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_hgrant_nxt    = '0;
        w_hgrant_nxt[i] = 1'b1;
      end
    end
    if (w_req == '0 && !w_mask_nxt[DEFAULT_MASTER])
      w_hgrant_nxt[DEFAULT_MASTER] = 1'b1;
  end

  always_comb begin
    w_gnt_idx = DEFAULT_MASTER;
    for (int i = 0; i < NM; i++) begin
      if (r_hgrant[i]) w_gnt_idx = LW'(i);
    end
  end

  assign w_gnt_any    = |r_hgrant;
  assign w_own_masked = |(r_hgrant & w_mask_nxt);
  // A newly split granted master is dropped even mid-burst.
  assign w_rearb = w_rearb_ok | w_own_masked | !w_gnt_any;

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rearb_ok  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_abort = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        w_rearb_ok = 1'b1;
        // Freeze the grant while the opening NONSEQ of a
        // protected sequence is on the bus.
        if (w_trans == HT_NONSEQ) begin
          if (w_fixed) begin
            w_rearb_ok = 1'b0;
            if (HREADY) begin
              w_cnt_load  = 1'b1;
              w_state_nxt = ARB_BURST;
            end
          end else if (w_own_lock) begin
            w_rearb_ok = 1'b0;
            if (HREADY) w_state_nxt = ARB_LOCKED;
          end
        end
      end
      ARB_BURST: begin
        if (w_trans == HT_IDLE || w_trans == HT_NONSEQ ||
            w_resp != HR_OKAY) begin
          w_cnt_abort = 1'b1;
          w_state_nxt = ARB_IDLE;
        end else if (w_cnt_dec && w_cnt_last) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        // Last locked beat completes before leaving.
        if (!w_own_lock && HREADY) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_split_mask <= '0;
      r_hgrant     <= DEF_GNT;
      r_hmaster    <= DEFAULT_MASTER;
      r_hmaster_d  <= DEFAULT_MASTER;
      r_hmastlock  <= 1'b0;
    end else begin
      r_split_mask <= w_mask_nxt;
      if (w_rearb) r_hgrant <= w_hgrant_nxt;
      if (HREADY) begin
        r_hmaster   <= w_gnt_idx;
        r_hmastlock <= w_gnt_any & HLOCK[w_gnt_idx];
        r_hmaster_d <= r_hmaster;
      end
    end
  end

  ahb_burst_beat_counter u_cnt (
    .i_clk      (HCLK),
    .i_rst      (HRESET),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .i_busy     (w_busy),
    .i_abort    (w_cnt_abort),
    .o_last     (w_cnt_last)
  );

  assign HGRANT    = r_hgrant;
  assign HMASTER   = r_hmaster;
  assign HMASTLOCK = r_hmastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed cycle-vector bench for ahb_bus_arbiter.
// Each row drives one cycle and checks the registered outputs after it.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_I = 2'd0;
  localparam logic [1:0] T_B = 2'd1;
  localparam logic [1:0] T_N = 2'd2;
  localparam logic [1:0] T_S = 2'd3;
  localparam logic [2:0] SGL = 3'd0;
  localparam logic [2:0] W4  = 3'd2;
  localparam logic [2:0] I4  = 3'd3;
  localparam logic [2:0] I8  = 3'd5;
  localparam logic [2:0] I16 = 3'd7;
  localparam logic [1:0] OK  = 2'd0;
  localparam logic [1:0] SP  = 2'd3;

  logic       HCLK;
  logic       HRESET;
  logic [1:0] HBUSREQ;
  logic [1:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [1:0] HSPLIT;
  logic [1:0] HGRANT;
  logic [0:0] HMASTER;
  logic       HMASTLOCK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [1:0] resp;
    logic [1:0] spl;
    logic [1:0] gnt;
    logic       hm;
    logic       ml;
    int         mask;
  } vec_t;

  vec_t tbl[$];

  ahb_bus_arbiter dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HSPLIT    (HSPLIT),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(
    input logic rst, input logic [1:0] req,
    input logic [1:0] lock, input logic [1:0] trans,
    input logic [2:0] burst, input logic rdy,
    input logic [1:0] resp, input logic [1:0] spl,
    input logic [1:0] gnt, input logic hm,
    input logic ml, input int mask);
    vec_t v;
    v.rst = rst;   v.req = req;     v.lock = lock;
    v.trans = trans; v.burst = burst; v.rdy = rdy;
    v.resp = resp; v.spl = spl;     v.gnt = gnt;
    v.hm = hm;     v.ml = ml;       v.mask = mask;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    HRESET  = v.rst;
    HBUSREQ = v.req;
    HLOCK   = v.lock;
    HTRANS  = v.trans;
    HBURST  = v.burst;
    HREADY  = v.rdy;
    HRESP   = v.resp;
    HSPLIT  = v.spl;
    @(posedge HCLK);
    #1;
    chk({tag, ".HGRANT"}, 4'(HGRANT), 4'(v.gnt));
    chk({tag, ".HMASTER"}, 4'(HMASTER), 4'(v.hm));
    chk({tag, ".HMASTLOCK"}, 4'(HMASTLOCK), 4'(v.ml));
    if (v.mask >= 0)
      chk({tag, ".split_mask"}, 4'(dut.r_split_mask),
          4'(v.mask));
  endtask

  initial begin
    // reset and parking on CPU
    tbl.push_back(mk(1,2'b00,0,T_I,SGL,1,OK,0, 2'b01,0,0, 0));
    tbl.push_back(mk(0,2'b00,0,T_I,SGL,1,OK,0, 2'b01,0,0,-1));
    // DMA takes bus, INCR8 with CPU request from beat 2
    tbl.push_back(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,0,0,-1));
    tbl.push_back(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b10,0,T_N,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 0,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I8, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b01,0,T_I,SGL,1,OK,0, 2'b01,1,0,-1));
    tbl.push_back(mk(0,2'b01,0,T_I,SGL,1,OK,0, 2'b01,0,0,-1));
    // DMA WRAP4 with two BUSY cycles
    tbl.push_back(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,0,0,-1));
    tbl.push_back(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_N,W4, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,W4, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_B,W4, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_B,W4, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,W4, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,W4, 1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_I,SGL,1,OK,0, 2'b01,1,0,-1));
    tbl.push_back(mk(0,2'b01,0,T_I,SGL,1,OK,0, 2'b01,0,0,-1));
    // CPU INCR4 split on beat 1, then released
    tbl.push_back(mk(0,2'b11,0,T_N,I4, 1,OK,0, 2'b01,0,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_S,I4, 0,SP,0, 2'b10,0,0, 1));
    tbl.push_back(mk(0,2'b11,0,T_I,SGL,1,SP,0, 2'b10,1,0, 1));
    tbl.push_back(mk(0,2'b11,0,T_I,SGL,1,OK,0, 2'b10,1,0,-1));
    tbl.push_back(mk(0,2'b11,0,T_I,SGL,1,OK,1, 2'b01,1,0, 0));
    tbl.push_back(mk(0,2'b01,0,T_I,SGL,1,OK,0, 2'b01,0,0,-1));
    // CPU locked sequence of three SINGLEs
    tbl.push_back(mk(0,2'b11,1,T_I,SGL,1,OK,0, 2'b01,0,1,-1));
    tbl.push_back(mk(0,2'b11,1,T_N,SGL,1,OK,0, 2'b01,0,1,-1));
    tbl.push_back(mk(0,2'b10,1,T_N,SGL,1,OK,0, 2'b01,0,1,-1));
    tbl.push_back(mk(0,2'b10,0,T_N,SGL,1,OK,0, 2'b01,0,0,-1));
    tbl.push_back(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,0,0,-1));
    tbl.push_back(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,1,0,-1));

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // both masters split, everything masked, then reset
    step(mk(0,2'b11,0,T_N,I16,1,OK,0, 2'b10,1,0,-1), "s1");
    step(mk(0,2'b11,0,T_S,I16,1,OK,0, 2'b10,1,0,-1), "s2");
    step(mk(0,2'b11,0,T_S,I16,0,SP,0, 2'b01,1,0, 2), "s3");
    step(mk(0,2'b11,0,T_I,SGL,1,SP,0, 2'b01,0,0,-1), "s4");
    step(mk(0,2'b11,0,T_N,I16,1,OK,0, 2'b01,0,0,-1), "s5");
    step(mk(0,2'b11,0,T_S,I16,1,OK,0, 2'b01,0,0,-1), "s6");
    // release and set on the same bit: set wins
    step(mk(0,2'b11,0,T_S,I16,0,SP,1, 2'b00,0,0, 3), "s7");
    step(mk(0,2'b11,0,T_I,SGL,1,SP,0, 2'b00,0,0, 3), "s8");
    step(mk(1,2'b00,0,T_I,SGL,1,OK,0, 2'b01,0,0, 0), "s9");
    step(mk(0,2'b00,0,T_I,SGL,1,OK,0, 2'b01,0,0,-1), "s10");
    // reset in the middle of a DMA INCR16
    step(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,0,0,-1), "s11");
    step(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,1,0,-1), "s12");
    step(mk(0,2'b10,0,T_N,I16,1,OK,0, 2'b10,1,0,-1), "s13");
    step(mk(0,2'b10,0,T_S,I16,1,OK,0, 2'b10,1,0,-1), "s14");
    step(mk(0,2'b11,0,T_S,I16,1,OK,0, 2'b10,1,0,-1), "s15");
    step(mk(1,2'b11,0,T_S,I16,1,OK,0, 2'b01,0,0, 0), "s16");
    step(mk(0,2'b10,0,T_I,SGL,1,OK,0, 2'b10,0,0,-1), "s17");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
